// File: rtl/fsm_tbl_pkg.sv
// Shared definitions for the table-driven FSM engine: control-state
// encodings, default widths and the power-on transition table.
package fsm_tbl_pkg;

  localparam int unsigned ST_W_DEF  = 3;
  localparam int unsigned OUT_W_DEF = 3;
  localparam int unsigned DEF_DEPTH = 16;

  typedef enum logic [1:0] {
    CTRL_IDLE = 2'b00,
    CTRL_RUN  = 2'b01,
    CTRL_HALT = 2'b10
  } ctrl_e;

  // Entry format {next_state[5:3], out[2:0]}, indexed by {a, state}.
  localparam logic [5:0] DEF_TABLE [DEF_DEPTH] = '{
    6'd8,  6'd17, 6'd29, 6'd37, 6'd12, 6'd8,  6'd8,  6'd8,
    6'd8,  6'd8,  6'd45, 6'd14, 6'd20, 6'd29, 6'd8,  6'd8
  };

  // Default entry for any index; entries past the built-in table load as zero.
  function automatic logic [5:0] def_entry(input int unsigned idx);
    logic [3:0] w_idx;
    w_idx = idx[3:0];
    if (idx < DEF_DEPTH) return DEF_TABLE[w_idx];
    return '0;
  endfunction

endpackage

// File: rtl/fsm_table_ctrl_if.sv
// Table write port (valid/ready) of fsm_table_ctrl.
// master drives a write request; slave (the engine) returns wr_ready.
interface fsm_table_ctrl_if
  import fsm_tbl_pkg::*;
#(
  parameter int unsigned ST_W  = ST_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ST_W:0]         wr_addr;
  logic [ST_W+OUT_W-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/fsm_tbl_mem.sv
// Transition table storage: register array that reloads the default table
// on reset, one synchronous write port and one combinational read port.
module fsm_tbl_mem
  import fsm_tbl_pkg::*;
#(
  parameter int unsigned ST_W  = ST_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [ST_W:0]         i_waddr,
  input  logic [ST_W+OUT_W-1:0] i_wdata,
  input  logic [ST_W:0]         i_raddr,
  output logic [ST_W+OUT_W-1:0] o_rdata
);
  localparam int unsigned DEPTH = 2 ** (ST_W + 1);
  localparam int unsigned W     = ST_W + OUT_W;

  logic [W-1:0] r_mem [DEPTH];

  // Table contents: default load on reset, single write per clock otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= W'(def_entry(i));
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fsm_table_ctrl.sv
// Table-driven Moore FSM engine with run controller (IDLE/RUN/HALT).
// The table is written over the wr interface while not running; in RUN the
// engine steps once per clock, optionally bounded by a run_len budget.
// Optional: define FSM_TABLE_CMP_EN to add ref_s/cmp_clr inputs and a sticky
// mismatch output comparing s against a reference during RUN.
module fsm_table_ctrl
  import fsm_tbl_pkg::*;
#(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned ST_W  = ST_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic [CNT_W-1:0] run_len,
  fsm_table_ctrl_if.slave  wr,
  output logic [OUT_W-1:0] s,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cyc_cnt
`ifdef FSM_TABLE_CMP_EN
  ,
  input  logic [OUT_W-1:0] ref_s,
  input  logic             cmp_clr,
  output logic             mismatch
`endif
);
  localparam int unsigned      W       = ST_W + OUT_W;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ctrl_e            r_ctrl, w_ctrl_nxt;
  logic [ST_W-1:0]  r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_len, w_len_nxt;
  logic             r_done, w_done_nxt;

  logic [W-1:0]     w_entry;
  logic [ST_W-1:0]  w_next_st;
  logic [OUT_W-1:0] w_out;
  logic             w_wr_ready;
  logic             w_we;
  logic             w_exhaust;
  logic             w_active;

  assign w_wr_ready  = (r_ctrl == CTRL_IDLE) || (r_ctrl == CTRL_HALT);
  assign w_we        = wr.wr_valid && w_wr_ready;
  assign wr.wr_ready = w_wr_ready;

  fsm_tbl_mem #(
    .ST_W  (ST_W),
    .OUT_W (OUT_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (reset),
    .i_we    (w_we),
    .i_waddr (wr.wr_addr),
    .i_wdata (wr.wr_data),
    .i_raddr ({a, r_state}),
    .o_rdata (w_entry)
  );

  assign w_next_st = w_entry[W-1:OUT_W];
  assign w_out     = w_entry[OUT_W-1:0];
  assign w_exhaust = (r_len != '0) && (r_cnt == r_len - CNT_ONE);
  assign w_active  = (r_ctrl == CTRL_RUN) || (r_ctrl == CTRL_HALT);

  // Control, engine state, step counter, budget and done pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctrl  <= CTRL_IDLE;
      r_state <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_ctrl  <= w_ctrl_nxt;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic: clear beats stop beats start; the budget-exhausting
  // step is still taken but the counter holds at run_len-1.
  always_comb begin
    w_ctrl_nxt  = r_ctrl;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_done_nxt  = 1'b0;
    if (clear) begin
      w_ctrl_nxt  = CTRL_IDLE;
      w_state_nxt = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_ctrl)
        CTRL_IDLE, CTRL_HALT: begin
          if (start && !stop) begin
            w_ctrl_nxt = CTRL_RUN;
            w_cnt_nxt  = '0;
            w_len_nxt  = run_len;
          end
        end
        CTRL_RUN: begin
          if (stop) begin
            w_ctrl_nxt = CTRL_HALT;
          end else begin
            w_state_nxt = w_next_st;
            if (w_exhaust) begin
              w_ctrl_nxt = CTRL_HALT;
              w_done_nxt = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + CNT_ONE;
            end
          end
        end
        default: w_ctrl_nxt = CTRL_IDLE;
      endcase
    end
  end

  assign s       = w_active ? w_out : '0;
  assign busy    = (r_ctrl == CTRL_RUN);
  assign done    = r_done;
  assign cyc_cnt = r_cnt;

`ifdef FSM_TABLE_CMP_EN
  logic r_mismatch;

  // Sticky compare flag: any RUN cycle with s != ref_s sets it until cmp_clr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mismatch <= 1'b0;
    end else if (cmp_clr) begin
      r_mismatch <= 1'b0;
    end else if ((r_ctrl == CTRL_RUN) && (s != ref_s)) begin
      r_mismatch <= 1'b1;
    end
  end

  assign mismatch = r_mismatch;
`endif

endmodule

// File: tb/tb_fsm_table_ctrl.sv
// Self-checking bench for fsm_table_ctrl: a behavioural model predicts each
// cycle's outputs into a scoreboard queue, popped and compared after the edge.
module tb_fsm_table_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       a, start, stop, clear;
  logic [7:0] run_len;
  logic [2:0] s;
  logic       busy, done;
  logic [7:0] cyc_cnt;
`ifdef FSM_TABLE_CMP_EN
  logic [2:0] ref_s;
  logic       cmp_clr, mismatch;
  logic       cmp_bad;
`endif

  fsm_table_ctrl_if #(.ST_W(3), .OUT_W(3)) wr_if ();

  fsm_table_ctrl #(.CNT_W(8), .ST_W(3), .OUT_W(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .a       (a),
    .start   (start),
    .stop    (stop),
    .clear   (clear),
    .run_len (run_len),
    .wr      (wr_if),
    .s       (s),
    .busy    (busy),
    .done    (done),
    .cyc_cnt (cyc_cnt)
`ifdef FSM_TABLE_CMP_EN
    ,
    .ref_s    (ref_s),
    .cmp_clr  (cmp_clr),
    .mismatch (mismatch)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam logic [5:0] TBL_DEF [16] = '{
    6'd8, 6'd17, 6'd29, 6'd37, 6'd12, 6'd8, 6'd8, 6'd8,
    6'd8, 6'd8,  6'd45, 6'd14, 6'd20, 6'd29, 6'd8, 6'd8
  };
  int   seq_exp [8] = '{1, 5, 5, 4, 1, 5, 5, 4};

  logic [5:0] m_tbl [16];
  int         m_ctrl;   // 0 idle, 1 run, 2 halt
  logic [2:0] m_state;
  logic [7:0] m_cnt, m_len;
  logic       m_done, m_mis;

  typedef struct {
    logic [2:0] s;
    logic       busy;
    logic       done;
    logic       rdy;
    logic [7:0] cnt;
    logic       mis;
  } exp_t;
  exp_t sb[$];

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_tbl[i] = TBL_DEF[i];
    m_ctrl = 0; m_state = 3'd0; m_cnt = 8'd0; m_len = 8'd0; m_done = 1'b0; m_mis = 1'b0;
  endtask

  function automatic logic [2:0] m_s();
    logic [3:0] idx;
    logic [5:0] ent;
    idx = {a, m_state};
    ent = m_tbl[idx];
    return (m_ctrl != 0) ? ent[2:0] : 3'd0;
  endfunction

  // Predict one clock edge, push the expectation, clock, then pop and compare.
  task automatic step();
    exp_t       e;
    logic [3:0] idx;
    logic [5:0] ent;
    int         nc;
    logic [2:0] ns;
    logic [7:0] ncnt, nlen;
    logic       nd;
    logic       wr_ok;
    idx   = {a, m_state};
    ent   = m_tbl[idx];
    wr_ok = wr_if.wr_valid && (m_ctrl != 1);
`ifdef FSM_TABLE_CMP_EN
    ref_s = cmp_bad ? ~m_s() : m_s();
    if (cmp_clr) m_mis = 1'b0;
    else if ((m_ctrl == 1) && (m_s() != ref_s)) m_mis = 1'b1;
`endif
    nc = m_ctrl; ns = m_state; ncnt = m_cnt; nlen = m_len; nd = 1'b0;
    if (clear) begin
      nc = 0; ns = 3'd0; ncnt = 8'd0;
    end else if (m_ctrl == 1) begin
      if (stop) nc = 2;
      else begin
        ns = ent[5:3];
        if ((m_len != 8'd0) && (m_cnt == m_len - 8'd1)) begin nc = 2; nd = 1'b1; end
        else ncnt = m_cnt + 8'd1;
      end
    end else if (start && !stop) begin
      nc = 1; ncnt = 8'd0; nlen = run_len;
    end
    if (wr_ok) m_tbl[wr_if.wr_addr] = wr_if.wr_data;
    m_ctrl = nc; m_state = ns; m_cnt = ncnt; m_len = nlen; m_done = nd;
    e.s = m_s(); e.busy = (m_ctrl == 1); e.done = m_done; e.rdy = (m_ctrl != 1);
    e.cnt = m_cnt; e.mis = m_mis;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("s", s, e.s);
    chk("busy", busy, e.busy);
    chk("done", done, e.done);
    chk("wr_ready", wr_if.wr_ready, e.rdy);
    chk("cyc_cnt", cyc_cnt, e.cnt);
`ifdef FSM_TABLE_CMP_EN
    chk("mismatch", mismatch, e.mis);
`endif
  endtask

  task automatic pulse_start(input logic [7:0] len);
    run_len = len; start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; a = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; run_len = 8'd0;
    wr_if.wr_valid = 1'b0; wr_if.wr_addr = '0; wr_if.wr_data = '0;
`ifdef FSM_TABLE_CMP_EN
    ref_s = 3'd0; cmp_clr = 1'b0; cmp_bad = 1'b0;
`endif
    m_reset();
    #12;
    chk("rst_s", s, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", cyc_cnt, 0);
    chk("rst_rdy", wr_if.wr_ready, 1);
`ifdef FSM_TABLE_CMP_EN
    chk("rst_mis", mismatch, 0);
`endif
    reset = 1'b1;

    // Free-running default sequence with a=0.
    pulse_start(8'd0);
    chk("seq0", s, 0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("seq", s, seq_exp[k]);
      chk("seq_busy", busy, 1);
    end
    pulse_clear();
    chk("clr_s", s, 0);

    // Input a steering the transitions.
    pulse_start(8'd0);
    step(); step();
    chk("st2_s", s, 5);
    a = 1'b1; #1;
    chk("a_comb", s, 5);
    step(); chk("a1_st5", s, 5);
    step(); chk("a1_st3", s, 6);
    a = 1'b0;
    pulse_clear();

    // Bounded runs and resume from HALT.
    pulse_start(8'd3);
    step(); step(); step();
    chk("done_pulse", done, 1);
    chk("halt_cnt", cyc_cnt, 2);
    chk("halt_busy", busy, 0);
    step();
    chk("done_once", done, 0);
    chk("halt_hold", s, 5);
    pulse_start(8'd2);
    chk("resume_s", s, 5);
    step(); chk("resume_st4", s, 4);
    step();
    chk("done2", done, 1);
    chk("halt_cnt2", cyc_cnt, 1);

    // Table write in HALT, then blocked write in RUN.
    wr_if.wr_valid = 1'b1; wr_if.wr_addr = 4'd1; wr_if.wr_data = 6'd0; #1;
    chk("rdy_halt", wr_if.wr_ready, 1);
    step();
    wr_if.wr_valid = 1'b0;
    chk("wr_visible", s, 0);
    pulse_start(8'd0);
    wr_if.wr_valid = 1'b1; wr_if.wr_addr = 4'd0; wr_if.wr_data = 6'd7; #1;
    chk("rdy_run", wr_if.wr_ready, 0);
    step(); step(); step();
    wr_if.wr_valid = 1'b0;
    step();
    chk("no_wr_run", s, 0);

    // stop+start in RUN halts; clear+start+write in HALT idles and writes.
    stop = 1'b1; start = 1'b1; step(); stop = 1'b0; start = 1'b0;
    chk("stop_busy", busy, 0);
    clear = 1'b1; start = 1'b1;
    wr_if.wr_valid = 1'b1; wr_if.wr_addr = 4'd1; wr_if.wr_data = 6'd3;
    step();
    clear = 1'b0; start = 1'b0; wr_if.wr_valid = 1'b0;
    chk("clr_idle_s", s, 0);
    chk("clr_idle_busy", busy, 0);
    pulse_start(8'd0);
    step(); chk("wr_with_clr", s, 3);
    step(); step();

    // Asynchronous reset mid-run reverts outputs and table.
    #2 reset = 1'b0;
    #1;
    chk("arst_s", s, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_cnt", cyc_cnt, 0);
    chk("arst_rdy", wr_if.wr_ready, 1);
    m_reset();
    #2 reset = 1'b1;
    pulse_start(8'd0);
    step(); chk("tbl_revert", s, 1);
    step(); chk("tbl_revert2", s, 5);

    // Free-run counter wrap.
    pulse_clear();
    pulse_start(8'd0);
    for (int k = 0; k < 256; k++) step();
    chk("wrap_cnt", cyc_cnt, 0);
    chk("wrap_busy", busy, 1);

`ifdef FSM_TABLE_CMP_EN
    // Sticky compare: one corrupted reference cycle, hold, then cmp_clr.
    step();
    chk("cmp_clean", mismatch, 0);
    cmp_bad = 1'b1; step(); cmp_bad = 1'b0;
    chk("cmp_set", mismatch, 1);
    step(); step();
    chk("cmp_hold", mismatch, 1);
    cmp_clr = 1'b1; step(); cmp_clr = 1'b0;
    chk("cmp_clr", mismatch, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
